// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences the datapath one state per cycle,
// stalls on mem_ready, flags unsupported opcodes and counts retirements.
module mips_multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 IRWrite,
  output logic                 ALUSrcA,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic [3:0]           state_out,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [CNT_WIDTH-1:0] ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FETCH;
      retired    <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      unique case (state)
        FETCH:
          if (mem_ready) state <= DECODE;
        DECODE:
          unique case (opcode)
            OP_R:         state <= R_EXEC;
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
            OP_ADDI:      state <= I_EXEC;
            default: begin
              state      <= FETCH;
              illegal_op <= 1'b1;
            end
          endcase
        MEM_ADDR:
          if (opcode == OP_SW)      state <= MEM_WRITE;
          else if (opcode == OP_LW) state <= MEM_READ;
          else                      state <= FETCH;
        MEM_READ:
          if (mem_ready) state <= MEM_WB;
        MEM_WRITE:
          if (mem_ready) begin
            state   <= FETCH;
            retired <= retired + ONE;
          end
        R_EXEC: state <= R_WB;
        I_EXEC: state <= I_WB;
        MEM_WB, R_WB, BRANCH, JUMP, I_WB: begin
          state   <= FETCH;
          retired <= retired + ONE;
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    unique case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      I_WB: RegWrite = 1'b1;
      default: ;
    endcase
    // An aborting reset must not let any write reach the datapath.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign state_out = state;

endmodule
